spart_driver: RTL and testbench

SPART_DRIVER -- requirements
Module: spart_driver

---
 rtl/spart_pkg.sv | 50 +++++
 rtl/spart_driver.sv | 150 +++++++++++++++
 tb/tb_spart_driver.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : spart_pkg
// Description : Shared types and helpers for the SPART echo driver: FSM state
//               encoding, SPART register addresses, baud divisor selection.
// Revision    : 1.0 - initial release
// ============================================================================
package spart_pkg;

  // Six states in a 3-bit encoding
  typedef enum logic [2:0] {
    CFG_LO   = 3'd0,
    CFG_HI   = 3'd1,
    RX_POLL  = 3'd2,
    RX_READ  = 3'd3,
    TX_POLL  = 3'd4,
    TX_WRITE = 3'd5
  } state_t;

  // SPART register map seen on ioaddr
  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  // Status register bit positions
  localparam int STAT_RDA = 0;
  localparam int STAT_TBR = 1;

  // Map the 2-bit baud select onto one of the four divisor values
  function automatic logic [15:0] sel_divisor(
    input logic [1:0]  cfg,
    input logic [15:0] div_4800,
    input logic [15:0] div_9600,
    input logic [15:0] div_19200,
    input logic [15:0] div_38400
  );
    logic [15:0] result;
    case (cfg)
      2'b00:   result = div_4800;
      2'b01:   result = div_9600;
      2'b10:   result = div_19200;
      default: result = div_38400;
    endcase
    return result;
  endfunction

endpackage : spart_pkg
`default_nettype wire

// File: rtl/spart_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : spart_driver
// Description : Programs the SPART baud divisor from br_cfg, then echoes each
//               received byte back out. Moore FSM with registered bus outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module spart_driver
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_4800  = 16'h028A,
  parameter logic [15:0] DIV_9600  = 16'h0145,
  parameter logic [15:0] DIV_19200 = 16'h00A2,
  parameter logic [15:0] DIV_38400 = 16'h0050
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       cfg_done,
  output logic [7:0] echo_cnt
);

  state_t      state_q,     state_d;
  logic        started_q,   started_d;
  logic [1:0]  br_cfg_q,    br_cfg_d;
  logic        cfg_done_q,  cfg_done_d;
  logic [7:0]  echo_cnt_q,  echo_cnt_d;
  logic [7:0]  echo_byte_q, echo_byte_d;
  logic        iocs_q,      iocs_d;
  logic        iorw_q,      iorw_d;
  logic [1:0]  ioaddr_q,    ioaddr_d;
  logic [7:0]  dout_q,      dout_d;
  logic [15:0] div_sel;

  // Next-state and datapath; bus controls are decoded from the next state so
  // the registered outputs always match the state register exactly.
  always_comb begin
    state_d     = state_q;
    started_d   = 1'b1;
    br_cfg_d    = br_cfg_q;
    cfg_done_d  = cfg_done_q;
    echo_cnt_d  = echo_cnt_q;
    echo_byte_d = echo_byte_q;

    if (!started_q) begin
      // First edge after reset release: enter CFG_LO with a fresh baud select
      state_d  = CFG_LO;
      br_cfg_d = br_cfg;
    end else begin
      case (state_q)
        CFG_LO: state_d = CFG_HI;
        CFG_HI: begin
          state_d    = RX_POLL;
          cfg_done_d = 1'b1;
        end
        RX_POLL: begin
          // A baud change wins over a waiting receive byte
          if (br_cfg != br_cfg_q) begin
            state_d    = CFG_LO;
            br_cfg_d   = br_cfg;
            cfg_done_d = 1'b0;
          end else if (databus[STAT_RDA]) begin
            state_d = RX_READ;
          end
        end
        RX_READ: begin
          echo_byte_d = databus;
          state_d     = TX_POLL;
        end
        TX_POLL: begin
          // br_cfg is not looked at here so the pending echo always completes
          if (databus[STAT_TBR]) state_d = TX_WRITE;
        end
        TX_WRITE: begin
          echo_cnt_d = echo_cnt_q + 8'd1;
          state_d    = RX_POLL;
        end
        default: state_d = CFG_LO;
      endcase
    end

    div_sel  = sel_divisor(br_cfg_d, DIV_4800, DIV_9600, DIV_19200, DIV_38400);
    iocs_d   = 1'b1;
    iorw_d   = 1'b1;
    ioaddr_d = ADDR_STATUS;
    dout_d   = 8'h00;
    case (state_d)
      CFG_LO: begin
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DIV_LO;
        dout_d   = div_sel[7:0];
      end
      CFG_HI: begin
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DIV_HI;
        dout_d   = div_sel[15:8];
      end
      RX_READ: ioaddr_d = ADDR_BUF;
      TX_WRITE: begin
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_BUF;
        dout_d   = echo_byte_d;
      end
      default: ioaddr_d = ADDR_STATUS;
    endcase
  end

  // FSM state, datapath and registered bus outputs; reset aborts any transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CFG_LO;
      started_q   <= 1'b0;
      br_cfg_q    <= 2'b00;
      cfg_done_q  <= 1'b0;
      echo_cnt_q  <= 8'h00;
      echo_byte_q <= 8'h00;
      iocs_q      <= 1'b0;
      iorw_q      <= 1'b1;
      ioaddr_q    <= ADDR_BUF;
      dout_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      started_q   <= started_d;
      br_cfg_q    <= br_cfg_d;
      cfg_done_q  <= cfg_done_d;
      echo_cnt_q  <= echo_cnt_d;
      echo_byte_q <= echo_byte_d;
      iocs_q      <= iocs_d;
      iorw_q      <= iorw_d;
      ioaddr_q    <= ioaddr_d;
      dout_q      <= dout_d;
    end
  end

  assign iocs     = iocs_q;
  assign iorw     = iorw_q;
  assign ioaddr   = ioaddr_q;
  assign cfg_done = cfg_done_q;
  assign echo_cnt = echo_cnt_q;

  // Only a selected write cycle drives the shared bus
  assign databus = (iocs_q && !iorw_q) ? dout_q : 8'hzz;

endmodule : spart_driver
`default_nettype wire

// File: tb/tb_spart_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spart_driver
// Description : Self-checking bench: SPART bus model, expected-write
//               scoreboard, randomized echo traffic and baud changes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spart_driver;

  localparam logic [15:0] DIVS [4] = '{16'h028A, 16'h0145, 16'h00A2, 16'h0050};

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       iocs, iorw, cfg_done;
  logic [1:0] ioaddr;
  logic [7:0] echo_cnt;
  wire  [7:0] databus;

  // SPART model: receive FIFO plus transmit-ready flag
  logic       tbr = 1'b1;
  logic [7:0] rx_mem [512];
  int         rx_wr = 0;
  int         rx_rd = 0;
  logic       rda;
  logic [7:0] bus_resp;

  wr_t  exp_q [$];
  wr_t  mon_e;
  int   total = 0;
  int   bad = 0;
  int   model_cnt = 0;
  logic [1:0] cur_cfg = 2'b01;
  logic prev_tbr_poll = 1'b0;

  spart_driver dut (
    .clk     (clk),
    .rst     (rst),
    .br_cfg  (br_cfg),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .cfg_done(cfg_done),
    .echo_cnt(echo_cnt)
  );

  always #5 clk = ~clk;

  assign rda = (rx_wr != rx_rd);
  always_comb begin
    bus_resp = 8'h00;
    if (ioaddr == 2'b01)      bus_resp = {6'b0, tbr, rda};
    else if (ioaddr == 2'b00) bus_resp = rx_mem[rx_rd[8:0]];
  end
  assign databus = (iocs && iorw) ? bus_resp : 8'hzz;

  // Buffer read consumes one received byte
  always @(posedge clk) begin
    if (rst && iocs && iorw && ioaddr == 2'b00 && rx_wr != rx_rd)
      rx_rd <= rx_rd + 1;
  end

  task automatic check(input bit ok, input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write is matched against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (iocs && !iorw) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_write", {6'b0, ioaddr, databus}, 16'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check(ioaddr == mon_e.addr, "wr_addr", {14'b0, ioaddr}, {14'b0, mon_e.addr});
          check(databus == mon_e.data, "wr_data", {8'b0, databus}, {8'b0, mon_e.data});
          if (mon_e.addr == 2'b00) begin
            check(prev_tbr_poll, "wr_after_tbr", {15'b0, prev_tbr_poll}, 16'h1);
            check(echo_cnt == model_cnt[7:0], "echo_cnt_pre", {8'b0, echo_cnt}, {8'b0, model_cnt[7:0]});
            check(cfg_done == 1'b1, "cfg_done_echo", {15'b0, cfg_done}, 16'h1);
            model_cnt = (model_cnt + 1) % 256;
          end else begin
            check(cfg_done == 1'b0, "cfg_done_cfg", {15'b0, cfg_done}, 16'h0);
          end
        end
      end else if (iocs && iorw) begin
        check(databus == bus_resp, "rd_bus", {8'b0, databus}, {8'b0, bus_resp});
        if (ioaddr == 2'b00)
          check(exp_q.size() > 0 && exp_q[0].addr == 2'b00, "rd_expected", 16'h1, 16'h0);
      end
      prev_tbr_poll = iocs && iorw && (ioaddr == 2'b01) && tbr;
    end else begin
      prev_tbr_poll = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_cfg(input logic [1:0] c);
    logic [15:0] d;
    d = DIVS[c];
    exp_q.push_back({2'b10, d[7:0]});
    exp_q.push_back({2'b11, d[15:8]});
  endtask

  task automatic set_cfg(input logic [1:0] c);
    br_cfg = c;
    if (c != cur_cfg) begin
      push_cfg(c);
      cur_cfg = c;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_mem[rx_wr[8:0]] = b;
    rx_wr++;
    exp_q.push_back({2'b00, b});
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && rx_wr == rx_rd) && n < budget) begin
      tick();
      n++;
    end
    check(exp_q.size() == 0 && rx_wr == rx_rd, {name, "_drain"}, exp_q.size(), 16'h0);
    exp_q.delete();
    tick();
  endtask

  task automatic wait_rx_empty(input string name);
    int n;
    n = 0;
    while (rx_wr != rx_rd && n < 50) begin
      tick();
      n++;
    end
    check(rx_wr == rx_rd, {name, "_rx_read"}, rx_wr - rx_rd, 16'h0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(iocs == 1'b0, {name, "_iocs"}, {15'b0, iocs}, 16'h0);
    check(iorw == 1'b1, {name, "_iorw"}, {15'b0, iorw}, 16'h1);
    check(ioaddr == 2'b00, {name, "_ioaddr"}, {14'b0, ioaddr}, 16'h0);
    check(cfg_done == 1'b0, {name, "_cfg_done"}, {15'b0, cfg_done}, 16'h0);
    check(echo_cnt == 8'h00, {name, "_echo_cnt"}, {8'b0, echo_cnt}, 16'h0);
  endtask

  task automatic check_first_cycle(input string name);
    @(posedge clk);
    #1;
    check(iocs && !iorw && ioaddr == 2'b10, name, {13'b0, iocs, iorw, ioaddr[0]}, 16'h4);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int polls;
    int n;
    logic [1:0] c;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");

    // Configure at 9600: 45 @10 then 01 @11
    push_cfg(2'b01);
    rst = 1'b1;
    check_first_cycle("first_cycle_lo");
    drain(50, "cfg9600");
    check(cfg_done == 1'b1, "cfg_done_after_cfg", {15'b0, cfg_done}, 16'h1);

    // Single echo
    send_byte(8'h5A);
    drain(50, "echo5a");
    check(echo_cnt == 8'h01, "echo_cnt_one", {8'b0, echo_cnt}, 16'h1);

    // Transmitter busy for 20 polls
    tbr = 1'b0;
    send_byte(8'hC3);
    wait_rx_empty("busy");
    polls = 0;
    repeat (20) begin
      @(negedge clk);
      if (iocs && iorw && ioaddr == 2'b01) polls++;
    end
    check(polls == 20, "tx_poll_count", polls, 16'd20);
    @(posedge clk);
    #2;
    tbr = 1'b1;
    drain(50, "busy");

    // Baud change and rda in the same cycle: configuration first
    set_cfg(2'b11);
    send_byte(8'hA7);
    drain(50, "cfg_vs_rda");

    // Baud change while configuring: reconfigure again afterwards
    set_cfg(2'b00);
    tick();
    set_cfg(2'b10);
    drain(50, "cfg_during_cfg");

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        c = 2'($urandom_range(0, 3));
        set_cfg(c);
      end
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) send_byte(8'($urandom));
      tbr = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 6)) tick();
      tbr = 1'b1;
      drain(300, "rand");
    end
    check(echo_cnt == model_cnt[7:0], "echo_cnt_rand", {8'b0, echo_cnt}, {8'b0, model_cnt[7:0]});

    // Count through 255 -> 00
    n = 256 - model_cnt;
    for (int k = 0; k < n; k++) begin
      send_byte(8'($urandom));
      if (k % 8 == 7) drain(300, "wrap");
    end
    drain(300, "wrap");
    check(echo_cnt == 8'h00, "echo_cnt_wrap", {8'b0, echo_cnt}, 16'h0);

    // Reset asserted while waiting in TX_POLL
    tbr = 1'b0;
    send_byte(8'h3C);
    wait_rx_empty("rst_txpoll");
    tick();
    tick();
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    model_cnt = 0;
    tbr = 1'b1;
    repeat (3) tick();
    push_cfg(cur_cfg);
    rst = 1'b1;
    check_first_cycle("first_cycle_lo_2");
    drain(50, "recfg");
    send_byte(8'h99);
    drain(50, "after_reset_echo");
    check(echo_cnt == 8'h01, "echo_cnt_after_reset", {8'b0, echo_cnt}, 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_spart_driver
`default_nettype wire
